// File: rtl/md_unit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_ctrl_if
// Description : Issue/result bundle between the E stage, the hazard unit and
//               the multiply/divide unit (md_unit_ctrl).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Signals
//   start      1   one-cycle issue strobe for a valid E-stage MDU instruction
//   md_op      3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6..7=no-op
//   rs_val     32  operand A (dividend / multiplicand / MTHI-MTLO source)
//   rt_val     32  operand B (divisor / multiplier)
//   d_uses_md  1   decode-stage instruction touches the MDU or HI/LO
//   busy       1   operation in progress (registered)
//   md_stall   1   stall request to the hazard unit (combinational)
//   hi         32  HI register
//   lo         32  LO register
// Modports
//   master : issuing side (pipeline / hazard unit)
//   slave  : the multiply/divide unit
// ============================================================================
interface md_unit_ctrl_if;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start,
    output md_op,
    output rs_val,
    output rt_val,
    output d_uses_md,
    input  busy,
    input  md_stall,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  md_op,
    input  rs_val,
    input  rt_val,
    input  d_uses_md,
    output busy,
    output md_stall,
    output hi,
    output lo
  );

endinterface : md_unit_ctrl_if
`default_nettype wire

// File: rtl/md_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_ctrl
// Description : Multi-cycle multiply/divide unit with HI/LO registers and its
//               sequencing controller. Sits beside the E-stage ALU, holds
//               busy for a fixed latency per operation class and raises the
//               stall request the hazard unit uses to freeze D.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
// Ports
//   clk    in   clock, all state changes on the rising edge
//   reset  in   synchronous active-high reset
//   md     slave modport of md_unit_ctrl_if:
//            start, md_op, rs_val, rt_val, d_uses_md  (inputs)
//            busy, md_stall, hi, lo                   (outputs)
// ============================================================================
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_unit_ctrl_if.slave  md
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter guard: the latency counter is 4 bits wide.
  // --------------------------------------------------------------------------
  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
    $error("md_unit_ctrl: MULT_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("md_unit_ctrl: DIV_CYCLES must be in 1..15");
  end

  localparam logic [3:0] C_MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] C_DIV_LOAD = 4'(DIV_CYCLES - 1);

  localparam logic [2:0] C_OP_MULT  = 3'd0;
  localparam logic [2:0] C_OP_MULTU = 3'd1;
  localparam logic [2:0] C_OP_DIV   = 3'd2;
  localparam logic [2:0] C_OP_DIVU  = 3'd3;
  localparam logic [2:0] C_OP_MTHI  = 3'd4;
  localparam logic [2:0] C_OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  // Latched op: bit 1 = divide class, bit 0 = unsigned variant.
  logic [1:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  // --------------------------------------------------------------------------
  // Datapath, evaluated from the latched operands only so that later changes
  // on rs_val/rt_val cannot leak into a running operation.
  // --------------------------------------------------------------------------
  logic        w_is_unsigned;
  logic        w_is_div;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;

  assign w_is_unsigned = op_q[0];
  assign w_is_div      = op_q[1];

  // One 64x64 multiplier covers both signednesses: operands are sign- or
  // zero-extended to 64 bits and the low 64 bits of the product are kept.
  assign w_mul_a = w_is_unsigned ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
  assign w_mul_b = w_is_unsigned ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
  assign w_prod  = w_mul_a * w_mul_b;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;

  // Signed division is done on magnitudes and the signs are reapplied:
  // quotient negative when signs differ (truncation toward zero), remainder
  // takes the sign of the dividend. The 0x80000000 / -1 corner falls out
  // naturally: magnitude 0x80000000 / 1 with equal signs gives 0x80000000, 0.
  assign w_a_neg    = ~w_is_unsigned & a_q[31];
  assign w_b_neg    = ~w_is_unsigned & b_q[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - a_q) : a_q;
  assign w_b_mag    = w_b_neg ? (32'd0 - b_q) : b_q;
  assign w_div_zero = (b_q == 32'd0);
  // Keep the divider's divisor nonzero; the result is discarded in that case.
  assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
  assign w_uquot    = w_a_mag / w_b_safe;
  assign w_urem     = w_a_mag % w_b_safe;
  assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uquot) : w_uquot;
  assign w_rem      = w_a_neg ? (32'd0 - w_urem) : w_urem;

  // --------------------------------------------------------------------------
  // Next-state / register-update logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (md.start) begin
          case (md.md_op)
            C_OP_MULT, C_OP_MULTU: begin
              op_d    = md.md_op[1:0];
              a_d     = md.rs_val;
              b_d     = md.rt_val;
              cnt_d   = C_MUL_LOAD;
              state_d = S_RUN;
            end
            C_OP_DIV, C_OP_DIVU: begin
              op_d    = md.md_op[1:0];
              a_d     = md.rs_val;
              b_d     = md.rt_val;
              cnt_d   = C_DIV_LOAD;
              state_d = S_RUN;
            end
            C_OP_MTHI: hi_d = md.rs_val;
            C_OP_MTLO: lo_d = md.rs_val;
            default:   ; // 6..7 are no-ops
          endcase
        end
      end

      S_RUN: begin
        // Any start seen here is a hazard-unit protocol violation and is
        // deliberately ignored so the running operation stays intact.
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (w_is_div) begin
            if (!w_div_zero) begin
              hi_d = w_rem;
              lo_d = w_quot;
            end
          end else begin
            hi_d = w_prod[63:32];
            lo_d = w_prod[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign md.busy = (state_q == S_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  // Includes the issue cycle itself, since busy only rises one cycle later.
  assign md.md_stall = md.d_uses_md & ((state_q == S_RUN) | md.start);

endmodule : md_unit_ctrl
`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit_ctrl
// Description : Self-checking bench for md_unit_ctrl. A behavioural model of
//               the HI/LO results (64-bit integer arithmetic) and of the
//               busy/stall timing produces every expected value.
// Revision    : 1.0  initial release
// ============================================================================
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_unit_ctrl_if md ();

  md_unit_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural result of one MDU instruction.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ohi, input logic [31:0] olo,
                       output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     t, t2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nhi = ohi;
    nlo = olo;
    lat = 0;
    case (op)
      3'd0: begin t = sa * sb; nhi = t[63:32]; nlo = t[31:0]; lat = MULT_N; end
      3'd1: begin t = ua * ub; nhi = t[63:32]; nlo = t[31:0]; lat = MULT_N; end
      3'd2: begin
        lat = DIV_N;
        if (b != 32'd0) begin
          sq = sa / sb; sr = sa % sb;
          t = sq; t2 = sr;
          nlo = t[31:0]; nhi = t2[31:0];
        end
      end
      3'd3: begin
        lat = DIV_N;
        if (b != 32'd0) begin
          t = ua / ub; t2 = ua % ub;
          nlo = t[31:0]; nhi = t2[31:0];
        end
      end
      3'd4: nhi = a;
      3'd5: nlo = a;
      default: ;
    endcase
  endtask

  // Issues one instruction starting at the current (post-negedge) point and
  // follows it to completion; ends just after a negedge with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dum, input logic mid_change, input logic poke);
    logic [31:0] nhi, nlo;
    int lat;
    model(op, a, b, exp_hi, exp_lo, nhi, nlo, lat);
    md.start = 1'b1; md.md_op = op; md.rs_val = a; md.rt_val = b; md.d_uses_md = dum;
    #1;
    checks++;
    if (md.md_stall !== dum) begin
      errors++; $display("FAIL stall_issue op=%0d: got %b want %b", op, md.md_stall, dum);
    end
    @(posedge clk); #1;
    md.start = 1'b0; md.md_op = 3'($urandom);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (md.busy !== 1'b1 || md.md_stall !== dum || md.hi !== exp_hi || md.lo !== exp_lo) begin
        errors++;
        $display("FAIL run_cycle%0d op=%0d: busy=%b stall=%b hi=%h lo=%h want busy=1 stall=%b hi=%h lo=%h",
                 i, op, md.busy, md.md_stall, md.hi, md.lo, dum, exp_hi, exp_lo);
      end
      if (mid_change && i == 0) begin
        md.rs_val = $urandom; md.rt_val = $urandom;
      end
      if (poke && i == 1) begin
        $display("note: start issued while busy (hazard protocol violation, must be ignored)");
        md.start = 1'b1; md.md_op = 3'($urandom); md.rs_val = $urandom; md.rt_val = $urandom;
        #1;
        checks++;
        if (md.md_stall !== dum) begin
          errors++; $display("FAIL stall_poke: got %b want %b", md.md_stall, dum);
        end
        @(posedge clk); #1;
        md.start = 1'b0;
      end else begin
        @(posedge clk);
      end
    end
    @(negedge clk);
    exp_hi = nhi; exp_lo = nlo;
    checks++;
    if (md.busy !== 1'b0 || md.md_stall !== 1'b0 || md.hi !== exp_hi || md.lo !== exp_lo) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: busy=%b stall=%b hi=%h lo=%h want busy=0 stall=0 hi=%h lo=%h",
               op, a, b, md.busy, md.md_stall, md.hi, md.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    md.start = 1'b1; md.md_op = 3'd4; md.rs_val = 32'hDEADBEEF; md.rt_val = 32'd0;
    md.d_uses_md = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0 || md.md_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h stall=%b want 0/0/0/0",
               md.busy, md.hi, md.lo, md.md_stall);
    end
    md.start = 1'b0; md.d_uses_md = 1'b1; #1;
    checks++;
    if (md.md_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall_idle: got %b want 0", md.md_stall);
    end
    reset = 1'b0; md.d_uses_md = 1'b0;
    @(negedge clk);
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic test_mult;
    run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 1'b0);
    checks++;
    if (md.hi !== 32'hFFFFFFFF || md.lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL mult_const: hi=%h lo=%h want ffffffff/fffffffe", md.hi, md.lo);
    end
  endtask

  task automatic test_multu;
    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b1, 1'b0);
    checks++;
    if (md.hi !== 32'h00000001 || md.lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu_const: hi=%h lo=%h want 00000001/fffffffe", md.hi, md.lo);
    end
  endtask

  task automatic test_div;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (md.hi !== 32'hFFFFFFFF || md.lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_neg: hi=%h lo=%h want ffffffff/fffffffd", md.hi, md.lo);
    end
    run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (md.hi !== 32'd1 || md.lo !== 32'd3) begin
      errors++; $display("FAIL divu: hi=%h lo=%h want 00000001/00000003", md.hi, md.lo);
    end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (md.hi !== 32'd0 || md.lo !== 32'h80000000) begin
      errors++; $display("FAIL div_ovf: hi=%h lo=%h want 00000000/80000000", md.hi, md.lo);
    end
  endtask

  task automatic test_mt_and_div0;
    run_op(3'd4, 32'hAAAA0000, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(3'd5, 32'h00005555, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(3'd3, 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(3'd2, 32'h87654321, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (md.hi !== 32'hAAAA0000 || md.lo !== 32'h00005555) begin
      errors++; $display("FAIL div_zero_keep: hi=%h lo=%h want aaaa0000/00005555", md.hi, md.lo);
    end
  endtask

  task automatic test_stall;
    run_op(3'd0, 32'h00000123, 32'h00000456, 1'b1, 1'b0, 1'b0);
    run_op(3'd0, 32'h00000789, 32'h00000abc, 1'b0, 1'b0, 1'b0);
    md.d_uses_md = 1'b1; #1;
    checks++;
    if (md.md_stall !== 1'b0) begin
      errors++; $display("FAIL stall_idle: got %b want 0", md.md_stall);
    end
    md.d_uses_md = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    md.start = 1'b1; md.md_op = 3'd2; md.rs_val = 32'd100; md.rt_val = 32'd7;
    @(posedge clk); #1;
    md.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    checks++;
    if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
      errors++; $display("FAIL abort_now: busy=%b hi=%h lo=%h want 0/0/0", md.busy, md.hi, md.lo);
    end
    repeat (DIV_N + 2) @(negedge clk);
    checks++;
    if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
      errors++; $display("FAIL abort_later: busy=%b hi=%h lo=%h want 0/0/0", md.busy, md.hi, md.lo);
    end
  endtask

  task automatic test_start_while_busy;
    run_op(3'd1, 32'h0000FFFF, 32'h00010001, 1'b1, 1'b0, 1'b1);
    checks++;
    if (md.hi !== 32'h00000000 || md.lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL poke_const: hi=%h lo=%h want 00000000/ffffffff", md.hi, md.lo);
    end
    run_op(3'd3, 32'd1000, 32'd33, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_op(3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0);
    run_op(3'd2, 32'h00000064, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
    run_op(3'd5, 32'hCAFEF00D, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op(3'd6, 32'h11111111, 32'd3, 1'b1, 1'b0, 1'b0);
    run_op(3'd7, 32'h22222222, 32'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1, 2: b = 32'($urandom_range(1, 9));
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    reset = 1'b1;
    md.start = 1'b0; md.md_op = 3'd0; md.rs_val = 32'd0; md.rt_val = 32'd0;
    md.d_uses_md = 1'b0;
    @(negedge clk);
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_mt_and_div0;
    test_stall;
    test_reset_abort;
    test_start_while_busy;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_md_unit_ctrl
`default_nettype wire

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers and its sequencing controller.
- Sits beside the E-stage ALU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E and holds busy for a fixed latency.
- Generates the stall request that the hazard unit uses to freeze D while an MDU-dependent instruction waits.
- HI/LO feed the E-stage result mux for MFHI/MFLO, and from there the normal M/W writeback path.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle issue strobe for a valid E-stage MDU instruction.
- md_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6–7 are no-op.
- rs_val  in  32  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  32  operand B (divisor / multiplier).
- d_uses_md  in  1  decode-stage instruction is MULT*/DIV*/MFHI/MFLO/MTHI/MTLO.
- busy  out  1  operation in progress.
- md_stall  out  1  stall request to hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: on a clk edge with reset=1, busy=0, counter=0, hi=0, lo=0, latched operands/op cleared. Reset overrides start and aborts any in-progress operation with no HI/LO update.
- State machine: IDLE, RUN.
- IDLE:
  - start=1 with md_op 0–3: latch rs_val, rt_val and md_op. Load counter = MULT_CYCLES-1 (mul) or DIV_CYCLES-1 (div). Go to RUN. busy=1 from the next cycle.
  - start=1 with md_op 4 (MTHI): hi<=rs_val at that edge. Stay IDLE; busy stays 0.
  - start=1 with md_op 5 (MTLO): lo<=rs_val at that edge. Stay IDLE; busy stays 0.
  - start=1 with md_op 6–7: no effect.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter==0, write HI/LO from the latched operands, clear busy and return to IDLE.
  - busy is high for exactly N cycles. If start is sampled at edge k, the new hi/lo are visible after edge k+N, where N = MULT_CYCLES or DIV_CYCLES.
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit must prevent this via md_stall; the bench flags it as a protocol violation but the RTL must stay consistent.
- Arithmetic:
  - MULT: 64-bit signed product; hi=[63:32], lo=[31:0].
  - MULTU: 64-bit unsigned product; hi=[63:32], lo=[31:0].
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor==0 (DIV or DIVU): full busy latency still occurs; hi/lo unchanged at completion.
- Operand capture: results depend only on operands latched at start. Later changes to rs_val/rt_val do not affect the result.
- md_stall = d_uses_md & (busy | start), combinational.
  - Covers the cycle of issue itself, since busy rises one cycle after start.
  - md_stall never asserts when d_uses_md=0.
- Outputs hi/lo/busy are registered; md_stall is the only combinational output.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002, start at edge 0 -> busy=1 for 5 cycles; after edge 5 hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy=0.
- MULTU same operands -> after edge 5 hi=0x00000001, lo=0xFFFFFFFE. Change rs_val mid-run to 0x12345678 -> result unchanged.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide-by-zero and MTHI/MTLO:
  - MTHI rs=0xAAAA0000 -> hi=0xAAAA0000 next cycle, busy never asserts.
  - MTLO rs=0x5555 -> lo=0x00005555.
  - DIVU by 0 -> busy for 10 cycles, hi/lo still 0xAAAA0000/0x00005555.
- Stall and reset:
  - d_uses_md=1 held with MULT started at edge 0 -> md_stall=1 in the start cycle and all 5 busy cycles, 0 afterwards.
  - d_uses_md=0 -> md_stall=0 throughout.
  - reset at edge 3 of a DIV -> busy=0, hi=lo=0 next cycle, no later update.
  - start asserted during busy -> ignored; original result unaffected.
